mul2x2_err_sweeper: RTL and testbench
=====================================

# mul2x2_err_sweeper

Sequential error-characterisation stage wrapped around an approximate 2x2-bit multiplier netlist (4 inputs, 4 outputs, combinational). It drives all 16 operand vectors into the multiplier, consumes the 4-bit approximate product, and compares it against the exact product. It accumulates error statistics and flags any vector whose absolute error exceeds the error threshold (ET). It sits directly on the multiplier's input and output pins and reports one pass/fail verdict per sweep.

## Interface

Parameters:
- `ET`, 4: error threshold; a vector violates when |approx − exact| > ET.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  requests a sweep; sampled only in IDLE.
- `stim_o`  out  4  vector driven to the multiplier: `stim_o[i]` feeds input `in<i>`. Operand A = `stim_o[1:0]`, operand B = `stim_o[3:2]`.
- `approx_i`  in  4  multiplier outputs: `approx_i[i]` = `out<i>`, unsigned product.
- `busy`  out  1  high from the first SWEEP cycle through the DRAIN cycle.
- `done`  out  1  one-cycle pulse when results are final.
- `pass`  out  1  1 when `viol_cnt`==0 for the last completed sweep.
- `max_err`  out  4  largest absolute error seen.
- `err_cnt`  out  5  number of vectors with nonzero error (0..16).
- `viol_cnt`  out  5  number of vectors with error > ET (0..16).
- `sum_err`  out  8  sum of absolute errors (max 240; no overflow possible).
- `first_viol`  out  4  lowest vector index that violated; valid only when `viol_cnt`≠0.

## Operation

FSM states:
- **IDLE**
  - Holds the results of the last sweep.
  - `start`=1 → SWEEP. On that same edge: clear all statistics, set `stim_o`=0, set `pass`=0.
- **SWEEP**
  - `stim_o` increments by 1 every cycle.
  - On the edge where `stim_o`==15: `stim_o` wraps to 0 and the FSM moves to DRAIN.
- **DRAIN**
  - One cycle; the last vector finishes accumulating.
  - → IDLE, with `done`=1 and `pass` updated.

Pipeline:
- **S1** (every SWEEP edge): registers `{stim_o, approx_i}`. The multiplier is combinational, so `approx_i` corresponds to the current `stim_o`.
- **S2** (one edge later): computes
  - exact = A*B (4 bits, max 9);
  - err = |approx − exact| (4 bits);
  - updates the statistics.
- **Statistics update in S2:**
  - `max_err` = max(`max_err`, err).
  - `err_cnt` += (err≠0).
  - `viol_cnt` += (err>ET).
  - `sum_err` += err.
  - `first_viol` is loaded only on the first violation of the sweep.
- `pass` is computed at the DRAIN edge as (final `viol_cnt`==0), so it reflects the whole sweep.

## Timing

- Reset values:
  - `stim_o`=0, `busy`=0, `done`=0, `pass`=0.
  - All counters, `max_err` and `first_viol` = 0.
  - FSM = IDLE; S1/S2 valid bits cleared.
- Edge numbering: E0 = the edge that samples `start`=1 in IDLE.
  - E1..E16: S1 captures vectors 0..15.
  - E2..E17: S2 accumulates vectors 0..15.
  - E17 is the DRAIN edge.
- Result visibility:
  - `done` is high for exactly one cycle after E17, together with the final statistics.
  - `busy` falls at E17 as well.
  - Start-to-done latency is 17 cycles.
- `start` while busy: ignored, with no effect on the sweep.
- `start` in the same cycle that `done` is high: accepted, since the FSM is already in IDLE. A new sweep begins and the statistics clear.
- `rst_n`=0 mid-sweep: at the next edge every register returns to its reset value, with no `done` pulse. Partial results are discarded.
- `rst_n` takes priority over `start`.

## Test plan

1. **Exact model** (`approx_i` = A*B combinationally), pulse `start`:
   - `done` exactly 17 cycles later.
   - `pass`=1, `max_err`=0, `err_cnt`=0, `viol_cnt`=0, `sum_err`=0.
2. **`approx_i` stuck at 0:**
   - `sum_err`=36, `max_err`=9, `err_cnt`=9.
   - `viol_cnt`=3 (vectors 11, 14, 15), `first_viol`=11, `pass`=0.
3. **Exact except vector 5 returns 6** (exact 1, err 5):
   - `viol_cnt`=1, `first_viol`=5, `max_err`=5, `err_cnt`=1, `sum_err`=5, `pass`=0.
   - Repeat with vector 5 returning 5 (err 4 = ET): `viol_cnt`=0, `pass`=1, `err_cnt`=1, `sum_err`=4.
4. **`approx_i` stuck at 15:**
   - `sum_err`=204, `max_err`=15, `err_cnt`=16, `viol_cnt`=16, `first_viol`=0.
5. **Robustness:**
   - Pulse `start` again at cycle 5 of a sweep → ignored; `done` still at cycle 17 and results unchanged.
   - Assert `rst_n`=0 at cycle 8 → all outputs reset, no `done` pulse. A fresh sweep afterwards matches scenario 1.
6. **Back-to-back:** assert `start` during the `done` cycle. A second sweep runs with cleared statistics and produces identical results 17 cycles later.

Source files
------------

// File: rtl/mul2x2_err_sweeper.sv
// -----------------------------------------------------------------------------
// mul2x2_err_sweeper
// Sweeps all 16 operand vectors through an approximate 2x2 multiplier and
// accumulates error statistics against the exact product.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mul2x2_err_sweeper #(
   parameter int ET = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] stim_o,
   input  logic [3:0] approx_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] max_err,
   output logic [4:0] err_cnt,
   output logic [4:0] viol_cnt,
   output logic [7:0] sum_err,
   output logic [3:0] first_viol
);

   localparam logic [3:0] c_ET = 4'(ET);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       w_start_sweep;

   logic [3:0] r_stim;
   logic       r_s1_vld;
   logic [3:0] r_s1_stim;
   logic [3:0] r_s1_approx;
   logic       r_done;
   logic       r_pass;
   logic [3:0] r_max_err;
   logic [4:0] r_err_cnt;
   logic [4:0] r_viol_cnt;
   logic [7:0] r_sum_err;
   logic [3:0] r_first_viol;

   logic [3:0] w_exact;
   logic [3:0] w_err;
   logic       w_viol;
   logic [4:0] w_viol_cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_start_sweep = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt   = S_SWEEP;
               w_start_sweep = 1'b1;
            end
         end
         S_SWEEP: begin
            if (r_stim == 4'hF) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // S2 error evaluation on the vector captured by S1
   always_comb begin
      w_exact = {2'b00, r_s1_stim[1:0]} * {2'b00, r_s1_stim[3:2]};
      w_err   = (r_s1_approx >= w_exact) ? (r_s1_approx - w_exact)
                                         : (w_exact - r_s1_approx);
      w_viol  = (w_err > c_ET);
      w_viol_cnt_nxt = r_viol_cnt + {4'b0000, (r_s1_vld && w_viol)};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stim       <= 4'd0;
         r_s1_vld     <= 1'b0;
         r_s1_stim    <= 4'd0;
         r_s1_approx  <= 4'd0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_max_err    <= 4'd0;
         r_err_cnt    <= 5'd0;
         r_viol_cnt   <= 5'd0;
         r_sum_err    <= 8'd0;
         r_first_viol <= 4'd0;
      end else begin
         r_done      <= 1'b0;
         r_s1_vld    <= (r_state == S_SWEEP);
         r_s1_stim   <= r_stim;
         r_s1_approx <= approx_i;
         if (w_start_sweep) begin
            r_stim       <= 4'd0;
            r_pass       <= 1'b0;
            r_max_err    <= 4'd0;
            r_err_cnt    <= 5'd0;
            r_viol_cnt   <= 5'd0;
            r_sum_err    <= 8'd0;
            r_first_viol <= 4'd0;
         end else begin
            if (r_state == S_SWEEP) r_stim <= r_stim + 4'd1;
            if (r_s1_vld) begin
               if (w_err > r_max_err) r_max_err <= w_err;
               r_err_cnt  <= r_err_cnt + {4'b0000, (w_err != 4'd0)};
               r_sum_err  <= r_sum_err + {4'b0000, w_err};
               r_viol_cnt <= w_viol_cnt_nxt;
               if (w_viol && (r_viol_cnt == 5'd0)) r_first_viol <= r_s1_stim;
            end
            // the last vector lands on this same edge, so use the next count
            if (r_state == S_DRAIN) begin
               r_done <= 1'b1;
               r_pass <= (w_viol_cnt_nxt == 5'd0);
            end
         end
      end
   end

   assign stim_o     = r_stim;
   assign busy       = (r_state != S_IDLE);
   assign done       = r_done;
   assign pass       = r_pass;
   assign max_err    = r_max_err;
   assign err_cnt    = r_err_cnt;
   assign viol_cnt   = r_viol_cnt;
   assign sum_err    = r_sum_err;
   assign first_viol = r_first_viol;

endmodule

`default_nettype wire

// File: tb/tb_mul2x2_err_sweeper.sv
// -----------------------------------------------------------------------------
// tb_mul2x2_err_sweeper
// Directed testbench for mul2x2_err_sweeper with a behavioural multiplier.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mul2x2_err_sweeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] stim_o;
   logic [3:0] approx_i;
   logic       busy, done, pass;
   logic [3:0] max_err;
   logic [4:0] err_cnt, viol_cnt;
   logic [7:0] sum_err;
   logic [3:0] first_viol;

   int n_tests = 0;
   int n_fail  = 0;
   int mode    = 0;

   mul2x2_err_sweeper #(.ET(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stim_o(stim_o),
      .approx_i(approx_i), .busy(busy), .done(done), .pass(pass),
      .max_err(max_err), .err_cnt(err_cnt), .viol_cnt(viol_cnt),
      .sum_err(sum_err), .first_viol(first_viol)
   );

   always #5 clk = ~clk;

   // 0 exact, 1 stuck 0, 2 vector5->6, 3 vector5->5, 4 stuck 15
   always_comb begin
      logic [3:0] ex;
      ex = {2'b00, stim_o[1:0]} * {2'b00, stim_o[3:2]};
      case (mode)
         1:       approx_i = 4'd0;
         2:       approx_i = (stim_o == 4'd5) ? 4'd6 : ex;
         3:       approx_i = (stim_o == 4'd5) ? 4'd5 : ex;
         4:       approx_i = 4'd15;
         default: approx_i = ex;
      endcase
   end

   // Pulse start, optionally re-pulse start at cycle restart_at, return done latency
   task automatic run_sweep(input int restart_at, output int lat);
      lat   = -1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (k == restart_at) start = 1'b1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({stim_o, busy, done, pass} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got stim/busy/done/pass=%b want 0", {stim_o, busy, done, pass});
      end
      n_tests++;
      if ({max_err, err_cnt, viol_cnt, sum_err, first_viol} !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_stats: got %h want 0", {max_err, err_cnt, viol_cnt, sum_err, first_viol});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_exact();
      int lat;
      mode = 0;
      run_sweep(0, lat);
      n_tests++;
      if (lat !== 17) begin n_fail++; $display("FAIL exact_latency: got %0d want 17", lat); end
      n_tests++;
      if (pass !== 1'b1) begin n_fail++; $display("FAIL exact_pass: got %b want 1", pass); end
      n_tests++;
      if ({max_err, err_cnt, viol_cnt, sum_err} !== 22'd0) begin
         n_fail++;
         $display("FAIL exact_stats: max=%0d err=%0d viol=%0d sum=%0d want all 0", max_err, err_cnt, viol_cnt, sum_err);
      end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL exact_busy_fall: got %b want 0", busy); end
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL exact_done_width: got %b want 0", done); end
   endtask

   task automatic test_stuck0();
      int lat;
      mode = 1;
      run_sweep(0, lat);
      n_tests++;
      if (lat !== 17) begin n_fail++; $display("FAIL stuck0_latency: got %0d want 17", lat); end
      n_tests++;
      if (sum_err !== 8'd36 || max_err !== 4'd9 || err_cnt !== 5'd9) begin
         n_fail++;
         $display("FAIL stuck0_err: sum=%0d max=%0d cnt=%0d want 36 9 9", sum_err, max_err, err_cnt);
      end
      n_tests++;
      if (viol_cnt !== 5'd3 || first_viol !== 4'd11 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck0_viol: viol=%0d first=%0d pass=%b want 3 11 0", viol_cnt, first_viol, pass);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_vector();
      int lat;
      mode = 2;
      run_sweep(0, lat);
      n_tests++;
      if (viol_cnt !== 5'd1 || first_viol !== 4'd5 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL vec5_err5_viol: viol=%0d first=%0d pass=%b want 1 5 0", viol_cnt, first_viol, pass);
      end
      n_tests++;
      if (max_err !== 4'd5 || err_cnt !== 5'd1 || sum_err !== 8'd5) begin
         n_fail++;
         $display("FAIL vec5_err5_stats: max=%0d cnt=%0d sum=%0d want 5 1 5", max_err, err_cnt, sum_err);
      end
      @(posedge clk); #1;
      mode = 3;
      run_sweep(0, lat);
      n_tests++;
      if (viol_cnt !== 5'd0 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL vec5_err4_boundary: viol=%0d pass=%b want 0 1", viol_cnt, pass);
      end
      n_tests++;
      if (max_err !== 4'd4 || err_cnt !== 5'd1 || sum_err !== 8'd4) begin
         n_fail++;
         $display("FAIL vec5_err4_stats: max=%0d cnt=%0d sum=%0d want 4 1 4", max_err, err_cnt, sum_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stuck15();
      int lat;
      mode = 4;
      run_sweep(0, lat);
      n_tests++;
      if (sum_err !== 8'd204 || max_err !== 4'd15 || err_cnt !== 5'd16) begin
         n_fail++;
         $display("FAIL stuck15_err: sum=%0d max=%0d cnt=%0d want 204 15 16", sum_err, max_err, err_cnt);
      end
      n_tests++;
      if (viol_cnt !== 5'd16 || first_viol !== 4'd0 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck15_viol: viol=%0d first=%0d pass=%b want 16 0 0", viol_cnt, first_viol, pass);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_while_busy();
      int lat;
      mode = 2;
      run_sweep(5, lat);
      n_tests++;
      if (lat !== 17) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 17", lat); end
      n_tests++;
      if (viol_cnt !== 5'd1 || first_viol !== 4'd5 || sum_err !== 8'd5 || err_cnt !== 5'd1) begin
         n_fail++;
         $display("FAIL busy_start_stats: viol=%0d first=%0d sum=%0d cnt=%0d want 1 5 5 1", viol_cnt, first_viol, sum_err, err_cnt);
      end
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_reset_midsweep();
      int lat;
      bit seen_done;
      mode = 1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_rise: got %b want 1", busy); end
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_tests++;
      if ({stim_o, busy, done, pass, max_err, err_cnt, viol_cnt, sum_err, first_viol} !== 33'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got %h want 0", {stim_o, busy, done, pass, max_err, err_cnt, viol_cnt, sum_err, first_viol});
      end
      seen_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      n_tests++;
      if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", seen_done); end
      mode = 0;
      run_sweep(0, lat);
      n_tests++;
      if (lat !== 17 || pass !== 1'b1 || {max_err, err_cnt, viol_cnt, sum_err} !== 22'd0) begin
         n_fail++;
         $display("FAIL midrst_fresh: lat=%0d pass=%b sum=%0d want 17 1 0", lat, pass, sum_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat;
      int lat2;
      mode = 1;
      run_sweep(0, lat);
      // still inside the done cycle: start again immediately
      run_sweep(0, lat2);
      n_tests++;
      if (lat !== 17 || lat2 !== 17) begin
         n_fail++;
         $display("FAIL b2b_latency: got %0d,%0d want 17,17", lat, lat2);
      end
      n_tests++;
      if (sum_err !== 8'd36 || max_err !== 4'd9 || err_cnt !== 5'd9 || viol_cnt !== 5'd3 || first_viol !== 4'd11 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_stats: sum=%0d max=%0d cnt=%0d viol=%0d first=%0d pass=%b want 36 9 9 3 11 0",
                  sum_err, max_err, err_cnt, viol_cnt, first_viol, pass);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_exact();
      test_stuck0();
      test_single_vector();
      test_stuck15();
      test_start_while_busy();
      test_reset_midsweep();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
